// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            q_o    <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, mid-bit sampling and LSB-first assembly.
// Optional even-parity bit checking is enabled with `define UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DataBits  = 8,
    parameter int unsigned StopTicks = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick_i,
    input  logic                rx_i,
    output logic [DataBits-1:0] rx_data_o,
    output logic                rx_done_o,
    output logic                frame_err_o,
    output logic                parity_err_o
);

    localparam int unsigned SW = (StopTicks > 16) ? 5 : 4;
    localparam int unsigned NW = $clog2(DataBits);

    localparam logic [SW-1:0] MID_CNT   = SW'(MID_TICK);
    localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(StopTicks - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DataBits - 1);

    logic rx_s;

    rx_state_e              state_q, state_d;
    logic [SW-1:0]          s_cnt_q, s_cnt_d;
    logic [NW-1:0]          n_cnt_q, n_cnt_d;
    logic [DataBits-1:0]    shift_q, shift_d;
    logic [DataBits-1:0]    data_q,  data_d;
    logic                   done_q,  done_d;
    logic                   ferr_q,  ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_q,   par_d;
    logic                   perr_q,  perr_d;
`endif

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif

        case (state_q)
            // Start detection is not gated by tick_i.
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (tick_i) begin
                    if (s_cnt_q == MID_CNT) begin
                        s_cnt_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick_i) begin
                    if (s_cnt_q == BIT_LAST) begin
                        shift_d = {rx_s, shift_q[DataBits-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_i) begin
                    if (s_cnt_q == BIT_LAST) begin
                        par_d   = rx_s;
                        s_cnt_d = '0;
                        state_d = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick_i) begin
                    if (s_cnt_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        data_d  = shift_q;
                        ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_q ^ (^shift_q);
`endif
                        s_cnt_d = '0;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data_o   = data_q;
    assign rx_done_o   = done_q;
    assign frame_err_o = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
